// File: rtl/dct_stream_ctrl_pkg.sv
// Shared types and constants for the DCT stream controller.
package dct_ctrl_pkg;

    localparam int BLK    = 64;
    localparam int PIX_W  = 8;
    localparam int COEF_W = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PAD  = 2'd2
    } state_e;

endpackage

// File: rtl/dct_stream_ctrl_if.sv
// Upstream pixel valid/ready handshake between a source and the controller.
interface dct_stream_ctrl_if;
    import dct_ctrl_pkg::*;

    logic [PIX_W-1:0] pix_in;
    logic             pix_valid;
    logic             pix_ready;

    modport master (output pix_in, output pix_valid, input pix_ready);
    modport slave  (input pix_in, input pix_valid, output pix_ready);

endinterface

// File: rtl/dct_stream_ctrl_fifo.sv
// Pixel FIFO: synchronous push/pop, occupancy count, registered ready, and a
// registered read port that drives the core input directly (zero when idle).
module dct_pix_fifo #(
    parameter int DEPTH = 128,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic [$clog2(DEPTH):0]     count_next,
    output logic                       ready
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_M1 = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] CNT_M2 = (AW+1)'(DEPTH - 2);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic [W-1:0]  dout_q, dout_d;
    logic          ready_q, ready_d;

    // Pointer/count update; ready looks one push ahead so it can be registered.
    always_comb begin
        wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        dout_d  = pop ? mem[rptr_q] : '0;
        ready_d = (count_q <= CNT_M2) || ((count_q == CNT_M1) && !push);
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
        end
    end

    // Storage array, written on every accepted push.
    always_ff @(posedge clk) begin
        if (push) mem[wptr_q] <= din;
    end

    assign dout       = dout_q;
    assign count      = count_q;
    assign count_next = count_d;
    assign ready      = ready_q;

endmodule

// File: rtl/dct_stream_ctrl.sv
// DCT stream controller: buffers pixels, feeds the free-running DCT core in
// whole 64-pixel blocks (zero pad blocks on starvation, core held in reset when
// idle) and forwards only coefficients of real blocks with sop/eop framing.
// Optional block/pad statistics outputs: define DCT_STREAM_CTRL_STATS_EN.
module dct_stream_ctrl
    import dct_ctrl_pkg::*;
#(
    parameter int BLK        = 64,
    parameter int FIFO_DEPTH = 128,
    parameter int CORE_LAT   = 84,
    parameter int PAD_LIMIT  = 2
) (
    input  logic              CLK,
    input  logic              RST,
    dct_stream_ctrl_if.slave  pix,
    output logic [PIX_W-1:0]  xin,
    output logic              core_rst,
    input  logic [COEF_W-1:0] dct_in,
    input  logic              core_rdy,
    output logic [COEF_W-1:0] coef_out,
    output logic              coef_valid,
    output logic              coef_sop,
    output logic              coef_eop,
    output logic              err
`ifdef DCT_STREAM_CTRL_STATS_EN
   ,output logic [15:0]       blk_cnt,
    output logic [15:0]       pad_cnt
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] BLK_C   = CW'(BLK);
    localparam logic [7:0]    PAD_LIM = 8'(PAD_LIMIT);

    state_e               state_q, state_d;
    logic [5:0]           idx_q, idx_d;
    logic [7:0]           padcnt_q, padcnt_d;
    logic                 core_rst_q, core_rst_d;
    logic                 tag_q, tag_d;
    logic [CORE_LAT-1:0]  tag_sr_q, tag_sr_d;
    logic [5:0]           ocnt_q, ocnt_d;
    logic [COEF_W-1:0]    coef_out_q, coef_out_d;
    logic                 coef_valid_q, coef_valid_d;
    logic                 coef_sop_q, coef_sop_d;
    logic                 coef_eop_q, coef_eop_d;
    logic                 err_q, err_d;

    logic                 push, pop, tag_dly, tags_idle;
    logic [CW-1:0]        fifo_cnt, fifo_cnt_next;

    assign push = pix.pix_valid & pix.pix_ready;

    dct_pix_fifo #(.DEPTH(FIFO_DEPTH), .W(PIX_W)) u_fifo (
        .clk        (CLK),
        .rst        (RST),
        .push       (push),
        .din        (pix.pix_in),
        .pop        (pop),
        .dout       (xin),
        .count      (fifo_cnt),
        .count_next (fifo_cnt_next),
        .ready      (pix.pix_ready)
    );

    assign tag_dly   = tag_sr_q[CORE_LAT-1];
    assign tags_idle = !tag_q && (tag_sr_q == '0);

    // Block sequencer: state changes only at idx 63 so the core sees whole blocks.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        padcnt_d = padcnt_q;
        pop      = 1'b0;
        unique case (state_q)
            IDLE: begin
                idx_d    = '0;
                padcnt_d = '0;
                if (fifo_cnt >= BLK_C) state_d = RUN;
            end
            RUN: begin
                pop   = 1'b1;
                idx_d = idx_q + 6'd1;
                if (idx_q == 6'd63) begin
                    padcnt_d = '0;
                    state_d  = (fifo_cnt_next >= BLK_C) ? RUN : PAD;
                end
            end
            PAD: begin
                idx_d = idx_q + 6'd1;
                if (idx_q == 6'd63) begin
                    if (fifo_cnt_next >= BLK_C) begin
                        state_d  = RUN;
                        padcnt_d = '0;
                    end else if ((padcnt_q + 8'd1 >= PAD_LIM) && tags_idle) begin
                        state_d  = IDLE;
                        padcnt_d = '0;
                    end else begin
                        padcnt_d = (padcnt_q == 8'hFF) ? padcnt_q : padcnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tag delay line and output framing for coefficients of real pixels.
    always_comb begin
        core_rst_d   = (state_q == IDLE);
        tag_d        = pop;
        tag_sr_d     = {tag_sr_q[CORE_LAT-2:0], tag_q};
        coef_valid_d = tag_dly;
        coef_out_d   = tag_dly ? dct_in : coef_out_q;
        coef_sop_d   = tag_dly && (ocnt_q == 6'd0);
        coef_eop_d   = tag_dly && (ocnt_q == 6'd63);
        ocnt_d       = tag_dly ? ocnt_q + 6'd1 : ocnt_q;
        err_d        = err_q | (tag_dly & ~core_rdy);
    end

    // All controller state; reset wins over everything, including mid-block.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            padcnt_q     <= '0;
            core_rst_q   <= 1'b1;
            tag_q        <= 1'b0;
            tag_sr_q     <= '0;
            ocnt_q       <= '0;
            coef_out_q   <= '0;
            coef_valid_q <= 1'b0;
            coef_sop_q   <= 1'b0;
            coef_eop_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            padcnt_q     <= padcnt_d;
            core_rst_q   <= core_rst_d;
            tag_q        <= tag_d;
            tag_sr_q     <= tag_sr_d;
            ocnt_q       <= ocnt_d;
            coef_out_q   <= coef_out_d;
            coef_valid_q <= coef_valid_d;
            coef_sop_q   <= coef_sop_d;
            coef_eop_q   <= coef_eop_d;
            err_q        <= err_d;
        end
    end

    assign core_rst   = core_rst_q;
    assign coef_out   = coef_out_q;
    assign coef_valid = coef_valid_q;
    assign coef_sop   = coef_sop_q;
    assign coef_eop   = coef_eop_q;
    assign err        = err_q;

`ifdef DCT_STREAM_CTRL_STATS_EN
    logic [15:0] blk_cnt_q, blk_cnt_d, pad_cnt_q, pad_cnt_d;

    // Saturating counts of forwarded real blocks and completed pad blocks.
    always_comb begin
        blk_cnt_d = blk_cnt_q;
        pad_cnt_d = pad_cnt_q;
        if (coef_eop_q && blk_cnt_q != 16'hFFFF) blk_cnt_d = blk_cnt_q + 16'd1;
        if (state_q == PAD && idx_q == 6'd63 && pad_cnt_q != 16'hFFFF)
            pad_cnt_d = pad_cnt_q + 16'd1;
    end

    // Statistics registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            blk_cnt_q <= '0;
            pad_cnt_q <= '0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
            pad_cnt_q <= pad_cnt_d;
        end
    end

    assign blk_cnt = blk_cnt_q;
    assign pad_cnt = pad_cnt_q;
`endif

endmodule
